// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-operand forwarding mux.
// Holds the instruction on stall (issuing a bubble downstream) and refreshes held operands from write-back.
module id_ex_stage #(
  parameter int DATA_W    = 8,
  parameter int CTRL_W    = 12,
  parameter int MAX_STALL = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [1:0]        id_ra,
  input  logic [1:0]        id_rb,
  input  logic [DATA_W-1:0] id_ra_data,
  input  logic [DATA_W-1:0] id_rb_data,
  input  logic [1:0]        id_has_hazard,
  input  logic              id_we,
  input  logic              id_sw1,
  input  logic              id_sm2,
  input  logic              id_sw2,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] fwd_mem_alu,
  input  logic [DATA_W-1:0] fwd_wb_data,
  input  logic [DATA_W-1:0] fwd_in_port,
  input  logic              wb_we,
  input  logic [1:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [1:0]        ex_ra,
  output logic [1:0]        ex_rb,
  output logic [1:0]        ex_has_hazard,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic              ex_we,
  output logic              ex_sw1,
  output logic              ex_sm2,
  output logic              ex_sw2,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_bubble,
  output logic              stall_timeout
);

  localparam logic [7:0] STALL_CAP = 8'(MAX_STALL);

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_MEM_ALU = 2'b01,
    FWD_WB_DATA = 2'b10,
    FWD_IN_PORT = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [1:0]        ra;
    logic [1:0]        rb;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [1:0]        has_hazard;
    logic              we;
    logic              sw1;
    logic              sm2;
    logic              sw2;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  id_ex_t     ex_q, ex_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;

  // Priority flush > stall > load. While stalled the producer may retire from
  // WB, so its result is captured into the held operand rather than lost.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    ex_d        = ex_q;
    stall_cnt_d = '0;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      if (wb_we && (wb_dest == ex_q.ra)) ex_d.ra_data = wb_data;
      if (wb_we && (wb_dest == ex_q.rb)) ex_d.rb_data = wb_data;
      stall_cnt_d = (stall_cnt_q >= STALL_CAP) ? STALL_CAP : stall_cnt_q + 8'd1;
    end else begin
      ex_d.valid      = id_valid;
      ex_d.ra         = id_ra;
      ex_d.rb         = id_rb;
      ex_d.ra_data    = id_ra_data;
      ex_d.rb_data    = id_rb_data;
      ex_d.has_hazard = id_has_hazard;
      ex_d.we         = id_we;
      ex_d.sw1        = id_sw1;
      ex_d.sm2        = id_sm2;
      ex_d.sw2        = id_sw2;
      ex_d.ctrl       = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] held);
    case (fwd_sel_e'(sel))
      FWD_MEM_ALU: fwd_mux = fwd_mem_alu;
      FWD_WB_DATA: fwd_mux = fwd_wb_data;
      FWD_IN_PORT: fwd_mux = fwd_in_port;
      default:     fwd_mux = held;
    endcase
  endfunction

  // Forward codes are live, so a stalled instruction re-selects its sources every cycle.
  assign ex_op_a = fwd_mux(forward_a, ex_q.ra_data);
  assign ex_op_b = fwd_mux(forward_b, ex_q.rb_data);

  assign id_ready      = ~stall;
  assign ex_valid      = ex_q.valid;
  assign ex_ra         = ex_q.ra;
  assign ex_rb         = ex_q.rb;
  assign ex_has_hazard = ex_q.has_hazard & {2{ex_q.valid}};
  assign ex_bubble     = stall | ~ex_q.valid;
  assign ex_we         = ex_q.we  & ~ex_bubble;
  assign ex_sw1        = ex_q.sw1 & ~ex_bubble;
  assign ex_sm2        = ex_q.sm2 & ~ex_bubble;
  assign ex_sw2        = ex_q.sw2 & ~ex_bubble;
  assign ex_ctrl       = ex_bubble ? '0 : ex_q.ctrl;
  assign stall_timeout = (stall_cnt_q == STALL_CAP);

endmodule
